// File: rtl/usbfs_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : usbfs_pkt_tx
// Purpose  : USB full-speed packet transmitter. Serialises SYNC, PID, an
//            optional data payload and CRC16 onto the D+/D- pair. It uses
//            NRZI encoding with bit stuffing and closes each packet with an
//            SE0/SE0/J end-of-packet. Each bit lasts 4 cycles of the 48 MHz
//            clock.
// Ports    : i_clk_48MHz    - sole clock
//            i_rst          - synchronous active-high reset
//            i_valid/o_ready- packet request handshake (ready only in IDLE)
//            i_pid          - 4-bit PID to send
//            i_data         - payload, byte 0 in bits [7:0]
//            i_data_nBytes  - payload length (clamped to MAX_PKT)
//            o_dp/o_dn/o_oe - line levels and drive enable
//            o_inflight     - packet on the wire
//            o_eopDone      - one-cycle pulse when the bus is released
//            o_pidErr       - one-cycle pulse when a request is dropped
// Options  : `define USBFS_PKT_TX_PIDCHECK_EN to drop token/special PIDs
//            (o_pidErr pulses); without it every PID is transmitted and
//            o_pidErr is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module usbfs_pkt_tx #(
    parameter int MAX_PKT = 8
) (
    input  logic                         i_clk_48MHz,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [3:0]                   i_pid,
    input  logic [8*MAX_PKT-1:0]         i_data,
    input  logic [$clog2(MAX_PKT):0]     i_data_nBytes,
    output logic                         o_dp,
    output logic                         o_dn,
    output logic                         o_oe,
    output logic                         o_inflight,
    output logic                         o_eopDone,
    output logic                         o_pidErr
);

    localparam int c_bw = $clog2(MAX_PKT);
    localparam int c_nw = $clog2(MAX_PKT) + 1;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_sync = 3'd1;
    localparam logic [2:0] c_st_pid  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_crc  = 3'd4;
    localparam logic [2:0] c_st_eop  = 3'd5;

    logic [2:0]            r_state;
    logic [1:0]            r_div;
    logic [3:0]            r_bit;      // bit index within the current field
    logic [c_bw-1:0]       r_byte;     // payload byte index
    logic [c_nw-1:0]       r_nbytes;
    logic [3:0]            r_pid;
    logic [8*MAX_PKT-1:0]  r_data;
    logic [15:0]           r_crc;
    logic [2:0]            r_ones;     // run of 1s before the current bit
    logic                  r_stuff;    // current bit is a stuffed 0
    logic                  r_line;     // NRZI level of current bit, 1 = J
    logic                  r_dp;
    logic                  r_dn;
    logic                  r_oe;
    logic                  r_inflight;
    logic                  r_eop_done;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_drop;
    logic                  w_pid_err;
    logic [7:0]            w_pid_byte;
    logic                  w_is_data_pid;
    logic [7:0]            w_cur_data_byte;
    logic                  w_cur_bit;
    logic                  w_bit_end;
    logic                  w_need_stuff;
    logic                  w_last_byte;
    logic [15:0]           w_crc_next;
    logic [2:0]            w_n_state;
    logic [3:0]            w_n_bit;
    logic [c_bw-1:0]       w_n_byte;
    logic                  w_n_stuff;
    logic [7:0]            w_n_data_byte;
    logic                  w_n_bit_val;
    logic                  w_n_level;

    // ------------------------------------------------------------------
    // Optional PID filter: tokens and special PIDs are accepted but dropped
    // ------------------------------------------------------------------
`ifdef USBFS_PKT_TX_PIDCHECK_EN
    logic r_pid_err;

    // PID[1:0]=01 covers OUT/IN/SOF/SETUP; 1100/1000/0100 are PRE/SPLIT/PING.
    assign w_drop = (i_pid[1:0] == 2'b01) ||
                    ((i_pid[1:0] == 2'b00) && (i_pid != 4'b0000));

    always_ff @(posedge i_clk_48MHz) begin
        if (i_rst) begin
            r_pid_err <= 1'b0;
        end else begin
            r_pid_err <= w_accept && w_drop;
        end
    end

    assign w_pid_err = r_pid_err;
`else
    assign w_drop    = 1'b0;
    assign w_pid_err = 1'b0;
`endif

    // Ready is withheld in the pulse cycle of eopDone/pidErr so a held
    // i_valid launches the next packet only after the previous completes.
    assign o_ready  = (r_state == c_st_idle) && !r_eop_done && !w_pid_err && !i_rst;
    assign w_accept = i_valid && o_ready;
    assign w_start  = w_accept && !w_drop;

    assign w_pid_byte      = {~r_pid, r_pid};
    assign w_is_data_pid   = (r_pid[1:0] == 2'b11);
    assign w_cur_data_byte = r_data[{r_byte, 3'b000} +: 8];
    assign w_bit_end       = (r_state != c_st_idle) && (r_div == 2'd3);
    assign w_last_byte     = (({1'b0, r_byte} + c_nw'(1)) == r_nbytes);

    // Logical value of the bit currently on the wire
    always_comb begin
        w_cur_bit = 1'b1;
        case (r_state)
            c_st_sync: w_cur_bit = (r_bit == 4'd7);
            c_st_pid:  w_cur_bit = w_pid_byte[r_bit[2:0]];
            c_st_data: w_cur_bit = w_cur_data_byte[r_bit[2:0]];
            c_st_crc:  w_cur_bit = ~r_crc[0];
            default:   w_cur_bit = 1'b1;
        endcase
        if (r_stuff) begin
            w_cur_bit = 1'b0;
        end
    end

    assign w_need_stuff = !r_stuff && w_cur_bit && (r_ones == 3'd5) &&
                          ((r_state == c_st_pid) || (r_state == c_st_data) ||
                           (r_state == c_st_crc));

    // CRC is accumulated LSB-first over payload bits (reflected 0x8005) and
    // then shifted out; stuffed bits never touch it.
    always_comb begin
        w_crc_next = r_crc;
        if (w_bit_end && !r_stuff) begin
            if (r_state == c_st_data) begin
                w_crc_next = (r_crc[0] ^ w_cur_bit) ? ({1'b0, r_crc[15:1]} ^ 16'hA001)
                                                    : {1'b0, r_crc[15:1]};
            end else if (r_state == c_st_crc) begin
                w_crc_next = {1'b0, r_crc[15:1]};
            end
        end
    end

    // Position of the next bit. A stuffed bit keeps the pointers where they
    // are, so the following advance resumes from the bit that triggered it.
    always_comb begin
        w_n_state = r_state;
        w_n_bit   = r_bit;
        w_n_byte  = r_byte;
        w_n_stuff = 1'b0;
        if (w_need_stuff) begin
            w_n_stuff = 1'b1;
        end else begin
            case (r_state)
                c_st_sync: begin
                    if (r_bit == 4'd7) begin
                        w_n_state = c_st_pid;
                        w_n_bit   = 4'd0;
                    end else begin
                        w_n_bit = r_bit + 4'd1;
                    end
                end
                c_st_pid: begin
                    if (r_bit == 4'd7) begin
                        w_n_bit  = 4'd0;
                        w_n_byte = '0;
                        if (!w_is_data_pid) begin
                            w_n_state = c_st_eop;
                        end else if (r_nbytes == '0) begin
                            w_n_state = c_st_crc;
                        end else begin
                            w_n_state = c_st_data;
                        end
                    end else begin
                        w_n_bit = r_bit + 4'd1;
                    end
                end
                c_st_data: begin
                    if (r_bit == 4'd7) begin
                        w_n_bit = 4'd0;
                        if (w_last_byte) begin
                            w_n_state = c_st_crc;
                        end else begin
                            w_n_byte = r_byte + c_bw'(1);
                        end
                    end else begin
                        w_n_bit = r_bit + 4'd1;
                    end
                end
                c_st_crc: begin
                    if (r_bit == 4'd15) begin
                        w_n_state = c_st_eop;
                        w_n_bit   = 4'd0;
                    end else begin
                        w_n_bit = r_bit + 4'd1;
                    end
                end
                c_st_eop: begin
                    if (r_bit == 4'd2) begin
                        w_n_state = c_st_idle;
                        w_n_bit   = 4'd0;
                    end else begin
                        w_n_bit = r_bit + 4'd1;
                    end
                end
                default: begin
                    w_n_state = c_st_idle;
                end
            endcase
        end
    end

    assign w_n_data_byte = r_data[{w_n_byte, 3'b000} +: 8];

    always_comb begin
        w_n_bit_val = 1'b1;
        case (w_n_state)
            c_st_sync: w_n_bit_val = (w_n_bit == 4'd7);
            c_st_pid:  w_n_bit_val = w_pid_byte[w_n_bit[2:0]];
            c_st_data: w_n_bit_val = w_n_data_byte[w_n_bit[2:0]];
            c_st_crc:  w_n_bit_val = ~w_crc_next[0];
            default:   w_n_bit_val = 1'b1;
        endcase
        if (w_n_stuff) begin
            w_n_bit_val = 1'b0;
        end
    end

    // NRZI: a 0 toggles the line, a 1 holds it
    assign w_n_level = w_n_bit_val ? r_line : ~r_line;

    always_ff @(posedge i_clk_48MHz) begin
        if (i_rst) begin
            r_state    <= c_st_idle;
            r_div      <= 2'd0;
            r_bit      <= 4'd0;
            r_byte     <= '0;
            r_nbytes   <= '0;
            r_pid      <= 4'd0;
            r_data     <= '0;
            r_crc      <= 16'hFFFF;
            r_ones     <= 3'd0;
            r_stuff    <= 1'b0;
            r_line     <= 1'b1;
            r_dp       <= 1'b1;
            r_dn       <= 1'b0;
            r_oe       <= 1'b0;
            r_inflight <= 1'b0;
            r_eop_done <= 1'b0;
        end else if (w_start) begin
            r_state    <= c_st_sync;
            r_div      <= 2'd0;
            r_bit      <= 4'd0;
            r_byte     <= '0;
            r_pid      <= i_pid;
            r_data     <= i_data;
            r_nbytes   <= (i_data_nBytes > c_nw'(MAX_PKT)) ? c_nw'(MAX_PKT) : i_data_nBytes;
            r_crc      <= 16'hFFFF;
            r_ones     <= 3'd0;
            r_stuff    <= 1'b0;
            // First SYNC bit is a 0, so the line toggles from J to K
            r_line     <= 1'b0;
            r_dp       <= 1'b0;
            r_dn       <= 1'b1;
            r_oe       <= 1'b1;
            r_inflight <= 1'b1;
            r_eop_done <= 1'b0;
        end else begin
            r_eop_done <= 1'b0;
            r_crc      <= w_crc_next;
            if (r_state != c_st_idle) begin
                r_div <= r_div + 2'd1;
            end
            if (w_bit_end) begin
                r_state <= w_n_state;
                r_bit   <= w_n_bit;
                r_byte  <= w_n_byte;
                r_stuff <= w_n_stuff;
                r_ones  <= w_cur_bit ? (r_ones + 3'd1) : 3'd0;
                case (w_n_state)
                    c_st_idle: begin
                        r_oe       <= 1'b0;
                        r_inflight <= 1'b0;
                        r_eop_done <= 1'b1;
                        r_line     <= 1'b1;
                        r_dp       <= 1'b1;
                        r_dn       <= 1'b0;
                    end
                    c_st_eop: begin
                        // Two bit times of SE0 followed by one of J
                        r_dp <= (w_n_bit == 4'd2);
                        r_dn <= 1'b0;
                    end
                    default: begin
                        r_line <= w_n_level;
                        r_dp   <= w_n_level;
                        r_dn   <= ~w_n_level;
                    end
                endcase
            end
        end
    end

    assign o_dp       = r_dp;
    assign o_dn       = r_dn;
    assign o_oe       = r_oe;
    assign o_inflight = r_inflight;
    assign o_eopDone  = r_eop_done;
    assign o_pidErr   = w_pid_err;

endmodule
`default_nettype wire

// File: tb/tb_usbfs_pkt_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_usbfs_pkt_tx
// Purpose  : Directed self-checking bench for usbfs_pkt_tx. A line-level
//            receiver model samples mid-bit, NRZI-decodes, removes stuffed
//            bits and reassembles bytes for comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usbfs_pkt_tx;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_pid;
    logic [63:0] i_data;
    logic [3:0]  i_data_nBytes;
    logic        o_dp, o_dn, o_oe, o_inflight, o_eopDone, o_pidErr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] cap_vec;
    int cap_len, cap_oe, cap_infl, cap_done_cyc, cap_done_cnt;
    int cap_stuffs, cap_first_stuff, cap_end, cap_ready_hi, cap_err_cnt;
    logic cap_dp1;
    logic [1:0] lv[$];
    bit bits[$];

    always #10 clk = ~clk;

    usbfs_pkt_tx #(.MAX_PKT(8)) dut (
        .i_clk_48MHz  (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_pid        (i_pid),
        .i_data       (i_data),
        .i_data_nBytes(i_data_nBytes),
        .o_dp         (o_dp),
        .o_dn         (o_dn),
        .o_oe         (o_oe),
        .o_inflight   (o_inflight),
        .o_eopDone    (o_eopDone),
        .o_pidErr     (o_pidErr)
    );

    // Reference packet: SYNC, PID, payload and USB CRC16 for data PIDs
    function automatic logic [127:0] build_exp(input logic [3:0] pid, input int nb,
                                               input logic [63:0] d, output int len);
        logic [127:0] v;
        logic [15:0]  c;
        logic [7:0]   b;
        v = '0;
        v[7:0]  = 8'h80;
        v[15:8] = {~pid, pid};
        len = 2;
        if (pid[1:0] == 2'b11) begin
            c = 16'hFFFF;
            for (int i = 0; i < nb; i++) begin
                b = d[8*i +: 8];
                for (int j = 0; j < 8; j++) begin
                    if (c[0] ^ b[j]) c = (c >> 1) ^ 16'hA001;
                    else             c = c >> 1;
                end
                v[8*len +: 8] = b;
                len++;
            end
            c = ~c;
            v[8*len +: 8]     = c[7:0];
            v[8*(len+1) +: 8] = c[15:8];
            len += 2;
        end
        return v;
    endfunction

    task automatic issue(input logic [3:0] pid, input logic [3:0] nb, input logic [63:0] d);
        bit ok;
        @(negedge clk);
        i_pid = pid; i_data = d; i_data_nBytes = nb; i_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (o_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
            i_valid = 1'b0;
        end
        @(posedge clk);
    endtask

    // Records one packet from the cycle after acceptance until o_oe drops
    task automatic capture(input bit keep_valid);
        int prev, ones, lvl;
        bit b;
        cap_oe = 0; cap_infl = 0; cap_done_cyc = 0; cap_done_cnt = 0;
        cap_stuffs = 0; cap_first_stuff = -1; cap_end = 0; cap_ready_hi = 0;
        cap_err_cnt = 0; cap_vec = '0; cap_len = 0; cap_dp1 = 1'b1;
        lv.delete(); bits.delete();
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!keep_valid) i_valid = 1'b0;
                cap_dp1 = o_dp;
            end
            if (o_oe)       cap_oe++;
            if (o_inflight) cap_infl++;
            if (o_ready)    cap_ready_hi++;
            if (o_pidErr)   cap_err_cnt++;
            if (o_eopDone) begin
                cap_done_cnt++;
                if (cap_done_cyc == 0) cap_done_cyc = c;
            end
            if ((c % 4 == 2) && o_oe) lv.push_back({o_dp, o_dn});
            if (!o_oe) begin cap_end = c; break; end
        end
        if (cap_end == 0) begin
            n_tests++; n_fail++;
            $display("FAIL packet_timeout: o_oe=%b required 0 within 1000 cycles", o_oe);
        end
        prev = 1; ones = 0;
        foreach (lv[i]) begin
            if (lv[i] == 2'b00) break;
            lvl = int'(lv[i][1]);
            b = (lvl == prev);
            prev = lvl;
            if (ones == 6) begin
                cap_stuffs++;
                if (cap_first_stuff < 0) cap_first_stuff = bits.size();
                ones = 0;
            end else begin
                bits.push_back(b);
                ones = b ? ones + 1 : 0;
            end
        end
        cap_len = bits.size() / 8;
        for (int i = 0; i < cap_len * 8 && i < 128; i++) cap_vec[i] = bits[i];
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_pid = 4'd0; i_data = '0; i_data_nBytes = 4'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({o_ready, o_oe, o_dp, o_dn, o_inflight, o_eopDone, o_pidErr} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0010000",
                     {o_ready, o_oe, o_dp, o_dn, o_inflight, o_eopDone, o_pidErr});
        end
        i_rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b required 1", o_ready);
        end
    endtask

    task automatic test_ack();
        issue(4'b0010, 4'd0, 64'd0);
        capture(1'b0);
        n_tests++;
        if (cap_vec[15:0] !== 16'hD280 || cap_len != 2) begin
            n_fail++; $display("FAIL ack_bytes: got %h len %0d required d280 len 2", cap_vec[15:0], cap_len);
        end
        n_tests++;
        if (cap_oe != 76) begin n_fail++; $display("FAIL ack_oe_cycles: got %0d required 76", cap_oe); end
        n_tests++;
        if (cap_done_cyc != 77 || cap_done_cnt != 1) begin
            n_fail++; $display("FAIL ack_eopdone: got cycle %0d count %0d required 77 1", cap_done_cyc, cap_done_cnt);
        end
        n_tests++;
        if (cap_infl != 76) begin n_fail++; $display("FAIL ack_inflight: got %0d required 76", cap_infl); end
        n_tests++;
        if (cap_dp1 !== 1'b0) begin n_fail++; $display("FAIL ack_first_sync_bit: dp got %b required 0", cap_dp1); end
        n_tests++;
        if (o_ready !== 1'b0 || o_dp !== 1'b1 || o_dn !== 1'b0) begin
            n_fail++; $display("FAIL ack_eop_cycle: ready/dp/dn got %b%b%b required 010", o_ready, o_dp, o_dn);
        end
        @(negedge clk);
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready_return: got %b required 1", o_ready); end
    endtask

    task automatic test_data1_empty();
        issue(4'b1011, 4'd0, 64'd0);
        capture(1'b0);
        n_tests++;
        if (cap_vec[31:0] !== 32'h00004B80 || cap_len != 4) begin
            n_fail++; $display("FAIL data1_empty_bytes: got %h len %0d required 00004b80 len 4", cap_vec[31:0], cap_len);
        end
        n_tests++;
        if (cap_oe != 140 || cap_stuffs != 0) begin
            n_fail++; $display("FAIL data1_empty_timing: oe %0d stuffs %0d required 140 0", cap_oe, cap_stuffs);
        end
    endtask

    task automatic test_stuffing();
        issue(4'b0011, 4'd1, 64'hFF);
        capture(1'b0);
        n_tests++;
        if (cap_vec[39:0] !== 40'hFF00FFC380 || cap_len != 5) begin
            n_fail++; $display("FAIL stuff_bytes: got %h len %0d required ff00ffc380 len 5", cap_vec[39:0], cap_len);
        end
        n_tests++;
        if (cap_stuffs != 2 || cap_first_stuff != 20) begin
            n_fail++; $display("FAIL stuff_position: count %0d first %0d required 2 20", cap_stuffs, cap_first_stuff);
        end
        n_tests++;
        if (cap_oe != 180) begin n_fail++; $display("FAIL stuff_oe_cycles: got %0d required 180", cap_oe); end
    endtask

    task automatic test_data8();
        logic [127:0] ev;
        int el;
        ev = build_exp(4'b0011, 8, 64'h0706050403020100, el);
        issue(4'b0011, 4'd8, 64'h0706050403020100);
        capture(1'b0);
        n_tests++;
        if (cap_vec !== ev || cap_len != el) begin
            n_fail++; $display("FAIL data8_bytes: got %h len %0d required %h len %0d", cap_vec, cap_len, ev, el);
        end
        n_tests++;
        if (cap_done_cnt != 1) begin n_fail++; $display("FAIL data8_eopdone: got %0d required 1", cap_done_cnt); end
    endtask

    task automatic test_clamp();
        logic [127:0] ev;
        int el;
        ev = build_exp(4'b1011, 8, 64'h8877665544332211, el);
        issue(4'b1011, 4'd15, 64'h8877665544332211);
        capture(1'b0);
        n_tests++;
        if (cap_vec !== ev || cap_len != el) begin
            n_fail++; $display("FAIL clamp_bytes: got %h len %0d required %h len %0d", cap_vec, cap_len, ev, el);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'b0010, 4'd0, 64'd0);
        capture(1'b1);
        n_tests++;
        if (cap_ready_hi != 0 || o_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_busy: ready-high cycles %0d now %b required 0 0", cap_ready_hi, o_ready);
        end
        @(negedge clk);
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_eop: got %b required 1", o_ready); end
        @(posedge clk);
        capture(1'b0);
        n_tests++;
        if (cap_vec[15:0] !== 16'hD280 || cap_oe != 76) begin
            n_fail++; $display("FAIL b2b_second_pkt: got %h oe %0d required d280 oe 76", cap_vec[15:0], cap_oe);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen, oe_seen;
        issue(4'b0011, 4'd2, 64'hABCD);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)  i_valid = 1'b0;
            if (c == 20) i_rst = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if ({o_oe, o_dp, o_dn, o_inflight, o_eopDone} !== 5'b01000) begin
            n_fail++; $display("FAIL reset_mid_release: oe/dp/dn/infl/eop got %b required 01000",
                               {o_oe, o_dp, o_dn, o_inflight, o_eopDone});
        end
        i_rst = 1'b0;
        done_seen = 0; oe_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_eopDone) done_seen++;
            if (o_oe)      oe_seen++;
        end
        n_tests++;
        if (done_seen != 0 || oe_seen != 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: eopDone %0d oe %0d required 0 0", done_seen, oe_seen);
        end
    endtask

    task automatic test_pid_in();
`ifdef USBFS_PKT_TX_PIDCHECK_EN
        issue(4'b1001, 4'd0, 64'd0);
        @(negedge clk);
        i_valid = 1'b0;
        n_tests++;
        if ({o_pidErr, o_oe, o_ready} !== 3'b100) begin
            n_fail++; $display("FAIL pidchk_pulse: err/oe/ready got %b required 100", {o_pidErr, o_oe, o_ready});
        end
        @(negedge clk);
        n_tests++;
        if ({o_pidErr, o_oe, o_ready} !== 3'b001) begin
            n_fail++; $display("FAIL pidchk_recover: err/oe/ready got %b required 001", {o_pidErr, o_oe, o_ready});
        end
`else
        issue(4'b1001, 4'd0, 64'd0);
        capture(1'b0);
        n_tests++;
        if (cap_vec[15:0] !== 16'h6980 || cap_oe != 76 || cap_err_cnt != 0) begin
            n_fail++; $display("FAIL pid_in_sent: got %h oe %0d err %0d required 6980 76 0",
                               cap_vec[15:0], cap_oe, cap_err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data1_empty();
        test_stuffing();
        test_data8();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_pid_in();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usbfs_pkt_tx.md
USBFS_PKT_TX -- requirements
Module: usbfs_pkt_tx

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8, maximum data payload in bytes (legal values 8, 16, 32, 64).
REQ-002 SHALL have ports i_clk_48MHz (input, 1, sole clock) and i_rst (input, 1, reset); reset is synchronous and active-high.
REQ-003 SHALL have ports i_valid (input, 1) and o_ready (output, 1), a valid/ready packet request handshake.
REQ-004 SHALL have port i_pid (input, 4, PID to send).
REQ-005 SHALL have port i_data (input, 8*MAX_PKT, payload, byte 0 in bits [7:0]).
REQ-006 SHALL have port i_data_nBytes (input, $clog2(MAX_PKT)+1, payload length).
REQ-007 SHALL have ports o_dp and o_dn (output, 1 each, line levels) and o_oe (output, 1, drive enable).
REQ-008 SHALL have port o_inflight (output, 1, packet in progress).
REQ-009 SHALL have port o_eopDone (output, 1, one-cycle pulse at the end of the packet).
REQ-010 SHALL have port o_pidErr (output, 1, one-cycle pulse when a request is refused).

Function
REQ-011 SHALL capture i_pid, i_data and i_data_nBytes on acceptance (i_valid && o_ready); o_ready=1 only in IDLE.
REQ-012 SHALL sequence states IDLE -> SYNC -> PID -> DATA -> CRC -> EOP -> IDLE.
REQ-013 SHALL go PID -> EOP directly for non-data PIDs, and PID -> CRC when i_data_nBytes=0.
REQ-014 Data PIDs SHALL be DATA0 (4'b0011), DATA1 (4'b1011), DATA2 (4'b0111) and MDATA (4'b1111).
REQ-015 SHALL hold each bit for exactly 4 clk cycles; the bit divider resets on acceptance; the first SYNC bit SHALL appear on the cycle after acceptance.
REQ-016 SYNC SHALL be byte 0x80, PID byte SHALL be {~pid,pid}, and all bytes SHALL be sent LSB first.
REQ-017 CRC16 SHALL use poly 0x8005, init 0xFFFF, complemented result, sent LSB first.
REQ-018 SHALL use NRZI encoding: a 0 toggles the line, a 1 holds it; the line starts at J (dp=1, dn=0) before SYNC.
REQ-019 SHALL insert a 0 after six consecutive 1s in PID/DATA/CRC; the run counter spans field boundaries and clears after a stuffed bit.
REQ-020 A stuffed bit SHALL occupy one full bit time and SHALL NOT advance the payload pointer.
REQ-021 EOP SHALL be SE0 (dp=0, dn=0) for 2 bit times, then J for 1 bit time; o_oe deasserts the cycle after the J bit ends, and o_eopDone pulses in that same cycle.
REQ-022 o_inflight SHALL be 1 from the cycle after acceptance through the final J bit.
REQ-023 i_data_nBytes > MAX_PKT SHALL be clamped to MAX_PKT.
REQ-024 i_valid deasserted mid-packet SHALL have no effect on a packet in progress.
REQ-025 When o_oe=0, o_dp/o_dn SHALL idle at J.

Reset
REQ-026 During reset: o_ready=0, o_oe=0, o_dp=1, o_dn=0, o_inflight=0, o_eopDone=0, o_pidErr=0.
REQ-027 The state machine SHALL be in IDLE on the first cycle after reset; o_ready=1 on that cycle.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without EOP and release the bus on the next cycle.

Configuration
REQ-029 Macro USBFS_PKT_TX_PIDCHECK_EN SHALL enable the PID check.
REQ-030 With the macro defined, token and special PIDs (OUT, IN, SOF, SETUP, PRE, SPLIT, PING) SHALL be accepted but dropped: o_pidErr pulses in the cycle after acceptance, there is no bus activity, and o_ready=1 again the following cycle.
REQ-031 Without the macro, every PID SHALL be sent (non-data PIDs as PID-only packets) and o_pidErr SHALL be tied to 0.

Verification
REQ-032 ACK (pid 4'b0010) -> PID byte 0xD2 on the line, o_oe high 76 cycles (16 bits + 3 EOP bits, x4), o_eopDone at cycle 77.
REQ-033 DATA1 with nBytes=0 -> bytes 0x80, 0x4B, CRC 0x0000, no stuffing, o_oe high 140 cycles.
REQ-034 DATA0 with nBytes=1, byte 0xFF -> one stuffed 0 after the 4th data bit; looped into usbfsPktRx -> o_pid=4'b0011, o_dataOkay=1.
REQ-035 DATA0 with nBytes=8, bytes 0x00..0x07, looped into usbfsPktRx -> o_dataOkay=1; i_valid held high -> second packet accepted only after o_eopDone.
REQ-036 i_rst pulsed at cycle 20 of a DATA packet -> next cycle o_oe=0, dp=1, dn=0, and no o_eopDone.
REQ-037 With USBFS_PKT_TX_PIDCHECK_EN, IN (4'b1001) requested -> o_pidErr pulse, o_oe stays 0.
